// File: rtl/operand_accumulator_pkg.sv
// Shared definitions for the operand accumulator: mode encoding, FSM states
// and the active-low hex segment table (bit order g..a).
package operand_accumulator_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

endpackage

// File: rtl/key_debounce.sv
// Pushbutton front end: 2-flop synchroniser, stable-count debouncer and a
// one-cycle press pulse on an accepted 1->0 transition.
module key_debounce #(
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic press
);

  localparam int unsigned CW = $clog2(DEBOUNCE + 1);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive samples disagreeing with the accepted level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
      level <= 1'b1;
      cnt   <= '0;
      press <= 1'b0;
    end else begin
      sync1 <= key_n;
      sync2 <= sync1;
      press <= 1'b0;
      if (sync2 == level) begin
        cnt <= '0;
      end else if (cnt == CW'(DEBOUNCE - 1)) begin
        level <= sync2;
        cnt   <= '0;
        press <= ~sync2;
      end else begin
        cnt <= cnt + CW'(1);
      end
    end
  end

endmodule

// File: rtl/operand_accumulator.sv
// Switch-operand accumulator: latches CHANNELS operands, sums or subtracts
// them one per cycle on a calc press, and shows the result on hex digits.
module operand_accumulator
  import operand_accumulator_pkg::*;
#(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned CHANNELS = 2,
  parameter int unsigned DEBOUNCE = 16
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      key_clr_n,
  input  logic                      key_calc_n,
  input  logic                      key_mode_n,
  input  logic [CHANNELS*WIDTH-1:0] sw,
  output logic [CHANNELS*WIDTH-1:0] op_leds,
  output logic [WIDTH-1:0]          res,
  output logic                      res_ovf,
  output logic                      mode,
  output logic                      busy,
  output logic                      done,
  output logic [7*(WIDTH/4)-1:0]    seg_res
);

  localparam int unsigned DIGITS = WIDTH / 4;
  localparam int unsigned IDXW   = $clog2(CHANNELS);

  logic clr_ev;
  logic calc_ev;
  logic mode_ev;

  logic [CHANNELS*WIDTH-1:0]        sw_s1;
  logic [CHANNELS*WIDTH-1:0]        sw_s2;
  logic [CHANNELS-1:0][WIDTH-1:0]   op_q;
  logic [WIDTH-1:0]                 acc;
  logic                             ovf_acc;
  logic [IDXW-1:0]                  idx;
  state_t                           state;
  logic [WIDTH:0]                   step;

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_clr (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_clr_n),
    .press (clr_ev)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_calc (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_calc_n),
    .press (calc_ev)
  );

  key_debounce #(.DEBOUNCE(DEBOUNCE)) u_key_mode (
    .clk   (clk),
    .rst_n (rst_n),
    .key_n (key_mode_n),
    .press (mode_ev)
  );

  // Top bit of step is the carry (add) or borrow (sub) of this accumulation
  always_comb begin
    step = '0;
    if (mode == MODE_SUB) begin
      step = {1'b0, acc} - {1'b0, op_q[idx]};
    end else begin
      step = {1'b0, acc} + {1'b0, op_q[idx]};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sw_s1   <= '0;
      sw_s2   <= '0;
      op_q    <= '0;
      acc     <= '0;
      ovf_acc <= 1'b0;
      idx     <= '0;
      res     <= '0;
      res_ovf <= 1'b0;
      mode    <= MODE_ADD;
      busy    <= 1'b0;
      done    <= 1'b0;
      state   <= ST_IDLE;
    end else begin
      sw_s1 <= sw;
      sw_s2 <= sw_s1;
      done  <= 1'b0;
      if (clr_ev) begin
        op_q    <= '0;
        acc     <= '0;
        ovf_acc <= 1'b0;
        idx     <= '0;
        res     <= '0;
        res_ovf <= 1'b0;
        busy    <= 1'b0;
        state   <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            op_q <= sw_s2;
            if (mode_ev) begin
              mode <= ~mode;
            end
            if (calc_ev) begin
              acc     <= op_q[0];
              idx     <= IDXW'(1);
              ovf_acc <= 1'b0;
              busy    <= 1'b1;
              state   <= ST_ACCUM;
            end
          end
          ST_ACCUM: begin
            acc     <= step[WIDTH-1:0];
            ovf_acc <= ovf_acc | step[WIDTH];
            idx     <= idx + IDXW'(1);
            if (idx == IDXW'(CHANNELS - 1)) begin
              res     <= step[WIDTH-1:0];
              res_ovf <= ovf_acc | step[WIDTH];
              done    <= 1'b1;
              busy    <= 1'b0;
              idx     <= '0;
              state   <= ST_IDLE;
            end
          end
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  assign op_leds = op_q;

  for (genvar d = 0; d < DIGITS; d++) begin : g_seg
    assign seg_res[7*d +: 7] = HEX_SEG[res[4*d +: 4]];
  end

endmodule

// File: tb/tb_operand_accumulator.sv
// Directed bench: a 2-channel and a 4-channel accumulator driven through
// their debounced keys, with hand-computed results and timing checks.
module tb_operand_accumulator;

  localparam int D   = 4;
  localparam int WIN = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic        clr_a = 1'b1, calc_a = 1'b1, mode_a = 1'b1;
  logic [15:0] sw_a = '0;
  logic [15:0] op_leds_a;
  logic [7:0]  res_a;
  logic        res_ovf_a, mode_o_a, busy_a, done_a;
  logic [13:0] seg_a;

  logic        clr_b = 1'b1, calc_b = 1'b1, mode_b = 1'b1;
  logic [31:0] sw_b = '0;
  logic [31:0] op_leds_b;
  logic [7:0]  res_b;
  logic        res_ovf_b, mode_o_b, busy_b, done_b;
  logic [13:0] seg_b;

  always #5 clk = ~clk;

  operand_accumulator #(.WIDTH(8), .CHANNELS(2), .DEBOUNCE(D)) dut_a (
    .clk(clk), .rst_n(rst_n), .key_clr_n(clr_a), .key_calc_n(calc_a),
    .key_mode_n(mode_a), .sw(sw_a), .op_leds(op_leds_a), .res(res_a),
    .res_ovf(res_ovf_a), .mode(mode_o_a), .busy(busy_a), .done(done_a),
    .seg_res(seg_a)
  );

  operand_accumulator #(.WIDTH(8), .CHANNELS(4), .DEBOUNCE(D)) dut_b (
    .clk(clk), .rst_n(rst_n), .key_clr_n(clr_b), .key_calc_n(calc_b),
    .key_mode_n(mode_b), .sw(sw_b), .op_leds(op_leds_b), .res(res_b),
    .res_ovf(res_ovf_b), .mode(mode_o_b), .busy(busy_b), .done(done_b),
    .seg_res(seg_b)
  );

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic        sub;
    logic [7:0]  res;
    logic        ovf;
    logic [13:0] seg;
  } vec_t;

  vec_t va [10];

  int   checks = 0;
  int   errors = 0;
  int   busy_cnt, done_cnt, first_busy, done_at;
  logic exp_mode_a = 1'b0;
  logic exp_mode_b = 1'b0;
  logic [31:0] sw_b_alt = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Start times are cycle offsets (-1 = key untouched); each key is held low for hold cycles
  task automatic run_keys(input bit sel, input int clr_t, input int calc_t,
                          input int mode_t, input int hold, input int swap_at);
    logic kc, kk, km, bz, dn;
    busy_cnt = 0; done_cnt = 0; first_busy = -1; done_at = -1;
    for (int c = 0; c < WIN; c++) begin
      kc = !(clr_t  >= 0 && c >= clr_t  && c < clr_t  + hold);
      kk = !(calc_t >= 0 && c >= calc_t && c < calc_t + hold);
      km = !(mode_t >= 0 && c >= mode_t && c < mode_t + hold);
      if (sel) begin clr_b = kc; calc_b = kk; mode_b = km; end
      else     begin clr_a = kc; calc_a = kk; mode_a = km; end
      @(negedge clk);
      bz = sel ? busy_b : busy_a;
      dn = sel ? done_b : done_a;
      if (bz) begin
        busy_cnt++;
        if (first_busy < 0) first_busy = c;
      end
      if (dn) begin
        done_cnt++;
        done_at = c;
      end
      if (sel && c == swap_at) sw_b = sw_b_alt;
      @(posedge clk); #1;
    end
  endtask

  initial begin
    logic found;

    va[0] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, {7'h19, 7'h02}};
    va[1] = '{8'hF0, 8'h20, 1'b0, 8'h10, 1'b1, {7'h79, 7'h40}};
    va[2] = '{8'hF0, 8'h20, 1'b1, 8'hD0, 1'b0, {7'h21, 7'h40}};
    va[3] = '{8'h20, 8'hF0, 1'b1, 8'h30, 1'b1, {7'h30, 7'h40}};
    va[4] = '{8'h80, 8'h7F, 1'b1, 8'h01, 1'b0, {7'h40, 7'h79}};
    va[5] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, {7'h0E, 7'h0E}};
    va[6] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, {7'h40, 7'h40}};
    va[7] = '{8'h9C, 8'h00, 1'b0, 8'h9C, 1'b0, {7'h10, 7'h46}};
    va[8] = '{8'h0B, 8'h7D, 1'b0, 8'h88, 1'b0, {7'h00, 7'h00}};
    va[9] = '{8'hE7, 8'h00, 1'b1, 8'hE7, 1'b0, {7'h06, 7'h78}};

    #2;
    check("rst_res",     res_a,     8'h00);
    check("rst_ovf",     res_ovf_a, 1'b0);
    check("rst_mode",    mode_o_a,  1'b0);
    check("rst_busy",    busy_a,    1'b0);
    check("rst_done",    done_a,    1'b0);
    check("rst_op_leds", op_leds_a, 16'h0000);
    check("rst_seg",     seg_a,     {7'h40, 7'h40});
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      if (exp_mode_a != va[i].sub) begin
        run_keys(1'b0, -1, -1, 0, D + 2, -1);
        exp_mode_a = ~exp_mode_a;
        check("mode_toggle", mode_o_a, exp_mode_a);
        check("mode_no_busy", busy_cnt, 0);
      end
      sw_a = {va[i].b, va[i].a};
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("op_leds", op_leds_a, {va[i].b, va[i].a});
      @(posedge clk); #1;
      run_keys(1'b0, -1, 0, -1, D + 2, -1);
      check("res",        res_a,      va[i].res);
      check("res_ovf",    res_ovf_a,  va[i].ovf);
      check("seg_res",    seg_a,      va[i].seg);
      check("busy_cycles", busy_cnt,  1);
      check("done_pulses", done_cnt,  1);
      check("done_after_busy", done_at, first_busy + 1);
      check("calc_latency", first_busy, D + 3);
    end

    // Four channels; switches move while busy and must not reach the result
    sw_b = {8'h04, 8'h03, 8'h02, 8'h01};
    sw_b_alt = 32'h80808080;
    repeat (4) @(posedge clk); #1;
    run_keys(1'b1, -1, 0, -1, D + 2, D + 2);
    check("b_res",         res_b,     8'h0A);
    check("b_ovf",         res_ovf_b, 1'b0);
    check("b_busy_cycles", busy_cnt,  3);
    check("b_done_pulses", done_cnt,  1);
    check("b_done_after",  done_at,   first_busy + 3);
    check("b_op_reload",   op_leds_b, 32'h80808080);

    // Subtraction with a borrow only in the first step: flag must stay sticky
    run_keys(1'b1, -1, -1, 0, D + 2, -1);
    exp_mode_b = ~exp_mode_b;
    check("b_mode", mode_o_b, exp_mode_b);
    sw_b = {8'h01, 8'h01, 8'h20, 8'h10};
    repeat (4) @(posedge clk); #1;
    run_keys(1'b1, -1, 0, -1, D + 2, -1);
    check("b_sub_res",  res_b,     8'hEE);
    check("b_sub_ovf",  res_ovf_b, 1'b1);
    check("b_sub_done", done_cnt,  1);

    // clr lands one cycle into ACCUM
    run_keys(1'b1, 1, 0, -1, D + 2, -1);
    check("b_clr_busy",  busy_cnt,  1);
    check("b_clr_done",  done_cnt,  0);
    check("b_clr_res",   res_b,     8'h00);
    check("b_clr_ovf",   res_ovf_b, 1'b0);
    check("b_clr_mode",  mode_o_b,  exp_mode_b);

    // clr and calc accepted in the same cycle
    run_keys(1'b0, 0, 0, -1, D + 2, -1);
    check("a_clrcalc_busy", busy_cnt,  0);
    check("a_clrcalc_done", done_cnt,  0);
    check("a_clrcalc_res",  res_a,     8'h00);
    check("a_clrcalc_ovf",  res_ovf_a, 1'b0);
    check("a_clrcalc_mode", mode_o_a,  exp_mode_a);

    // Glitch shorter than the debounce window, then a proper press
    sw_a = {8'h11, 8'h22};
    repeat (4) @(posedge clk); #1;
    run_keys(1'b0, -1, 0, -1, D - 1, -1);
    check("glitch_busy", busy_cnt, 0);
    check("glitch_done", done_cnt, 0);
    run_keys(1'b0, -1, 0, -1, D + 2, -1);
    check("hold_done", done_cnt,  1);
    check("hold_res",  res_a,     8'h11);
    check("hold_ovf",  res_ovf_a, 1'b0);

    // Reset asserted while B is accumulating
    calc_b = 1'b0;
    found = 1'b0;
    for (int c = 0; c < 30 && !found; c++) begin
      @(negedge clk);
      if (busy_b) found = 1'b1;
    end
    check("rst_busy_seen", found, 1'b1);
    rst_n = 1'b0;
    calc_b = 1'b1;
    #1;
    check("midrst_busy",    busy_b,    1'b0);
    check("midrst_done",    done_b,    1'b0);
    check("midrst_res",     res_b,     8'h00);
    check("midrst_ovf",     res_ovf_b, 1'b0);
    check("midrst_mode",    mode_o_b,  1'b0);
    check("midrst_op_leds", op_leds_b, 32'h0);
    check("midrst_seg",     seg_b,     {7'h40, 7'h40});
    check("midrst_res_a",   res_a,     8'h00);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    done_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done_b) done_cnt++;
    end
    check("midrst_no_done", done_cnt, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
